spart_rx_shift_reg: RTL
=======================

Name: spart_rx_shift_reg

Overview:
- Receive-side shift register and framing FSM for the SPART serial port.
- Recovers 8N1 frames (start, 8 data bits LSB first, stop) from the rxd line using an oversampled baud tick from the baud generator.
- Holds the received byte for the bus interface with a receive-data-available flag plus framing and overrun error flags.

Parameters:
- OVERSAMPLE, 16, enable ticks per bit period; even, >= 4.
- CNT_W, 4, width of tick counter; must hold OVERSAMPLE-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- enable  input  1  oversample tick from baud generator, one-cycle pulse.
- rxd  input  1  asynchronous serial line, idle high.
- rda_clr  input  1  clears rda and overrun_err; pulsed on a bus read of the receive buffer.
- rx_data  output  8  last completed received byte.
- rda  output  1  receive data available.
- framing_err  output  1  stop bit of the last completed byte sampled low.
- overrun_err  output  1  a byte completed while rda was already set.
- rx_busy  output  1  FSM is not in IDLE.

Behaviour:
- Timing rules:
  - Synchronous active-high reset; one clock domain.
  - rxd passes through a 2-flop synchronizer to give rxd_s; both flops reset to 1. The synchronizer runs every clk.
  - The FSM and counters advance only on clk edges where enable=1, except for rda_clr handling.
- Reset values:
  - rx_data=8'h00, rda=0, framing_err=0, overrun_err=0, rx_busy=0.
  - FSM=IDLE, tick_cnt=0, bit_cnt=0, shift reg=8'h00.
  - Reset mid-frame abandons the frame. No flags change afterward until a new frame completes.
- IDLE:
  - On enable with rxd_s=0: go to START, tick_cnt=0.
- START:
  - On each enable, tick_cnt++.
  - When tick_cnt reaches OVERSAMPLE/2-1, sample rxd_s:
    - rxd_s=1: false start (glitch). Return to IDLE; no flag change.
    - rxd_s=0: go to DATA with tick_cnt=0, bit_cnt=0.
- DATA:
  - On each enable, tick_cnt++.
  - When tick_cnt reaches OVERSAMPLE-1 (bit centre), shift in LSB first: shreg <= {rxd_s, shreg[7:1]}; tick_cnt=0; bit_cnt++.
  - After the 8th bit, go to STOP.
- STOP:
  - At tick_cnt=OVERSAMPLE-1, sample rxd_s. On that same clk:
    - rx_data <= shreg.
    - framing_err <= ~rxd_s.
    - overrun_err <= 1 if rda=1.
    - rda <= 1.
  - If rxd_s=1, go to IDLE; else go to BREAK.
- BREAK:
  - Wait until an enable with rxd_s=1, then go to IDLE. This stops a held-low line from re-triggering a start.
- Data latency: rda rises 1 clk after the enable edge at the stop-bit centre, i.e. about 9.5 bit periods after the start edge plus the 2-clk synchronizer delay.
- rda_clr:
  - Acts on any clk, independent of enable; clears rda and overrun_err.
  - If rda_clr coincides with byte completion, completion wins: rda=1, and overrun_err is set only if rda was 1 before this edge. The byte is never lost.
- Overrun:
  - The new byte overwrites rx_data.
  - overrun_err stays set until rda_clr or rst.
- framing_err is updated only at byte completion; it is not cleared by rda_clr.
- rx_busy = (FSM != IDLE), registered with the state.

Optional Feature:
- Macro SPART_RX_PARITY_EN.
- When defined:
  - The frame becomes 8E1: a PARITY state is inserted between DATA and STOP, and the parity bit is sampled at its centre.
  - Adds output parity_err (1 bit, reset 0). At byte completion it is set to the XOR of the 8 data bits and the parity bit, so it is 1 on an even-parity mismatch.
  - rda latency grows by one bit period.
- When undefined:
  - No PARITY state and no parity_err port; the frame is 8N1 exactly as above.

Test Plan:
- Byte receive: OVERSAMPLE=16, enable every clk; drive frame for 8'hA5 (start 0; bits 1,0,1,0,0,1,0,1; stop 1) -> rx_data=8'hA5, rda=1, framing_err=0 about 154 clks after the start edge.
- False start: rxd low for 4 enables, then high -> FSM returns to IDLE; rda, rx_data and flags unchanged; rx_busy pulses then drops.
- Framing error and break: send 8'h3C with stop bit 0, then hold rxd low for 40 enables -> rx_data=8'h3C, rda=1, framing_err=1; FSM stays in BREAK with no new frame; after rxd goes high, the next 8'h01 frame gives framing_err=0.
- Overrun: receive 8'h11 and do not clear, then receive 8'h22 -> rx_data=8'h22, rda=1, overrun_err=1; rda_clr pulse -> rda=0, overrun_err=0.
- Simultaneous clear: with rda=0, pulse rda_clr on the exact completion clk of 8'h7E -> rda=1, overrun_err=0, rx_data=8'h7E.
- Reset mid-frame: assert rst after 4 data bits, release, then send 8'hC3 -> outputs at reset values until completion; then rx_data=8'hC3 with no stale bits. With SPART_RX_PARITY_EN, 8'hC3 with parity 1 gives parity_err=1, and with parity 0 gives parity_err=0.

Source files
------------

// File: rtl/spart_rx_shift_reg.sv
// spart_rx_shift_reg: SPART receive shift register and framing FSM.
// Recovers 8N1 frames from rxd using the oversampled enable tick.
// Holds the last byte with rda, framing_err and overrun_err flags.
// Optional macro SPART_RX_PARITY_EN: 8E1 frames, extra parity_err output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for a low rxd_s on an enable
// S_START  | timing to the start-bit centre to reject glitches
// S_DATA   | sampling 8 data bits at bit centres, LSB first
// S_PARITY | sampling the even-parity bit (SPART_RX_PARITY_EN only)
// S_STOP   | sampling the stop bit; the byte is committed here
// S_BREAK  | stop bit was low; wait for the line to return high
`timescale 1ns/1ps

module spart_rx_shift_reg #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rxd,
  input  logic       rda_clr,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       framing_err,
  output logic       overrun_err,
`ifdef SPART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t           state, state_nxt;
  logic             rxd_m, rxd_s;
  logic [CNT_W-1:0] tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             cnt_clr, cnt_inc, bit_clr, shift_en, byte_done;
  logic             tc_half, tc_full;
`ifdef SPART_RX_PARITY_EN
  logic             par_en;
  logic             par_bit;
`endif

  assign tc_half = (tick_cnt == HALF_TC);
  assign tc_full = (tick_cnt == FULL_TC);

  // Two-flop synchronizer on the asynchronous line, idle-high after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // State register; rx_busy is registered alongside so it tracks the state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rx_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      rx_busy <= (state_nxt != S_IDLE);
    end
  end

  // Next-state decode; the FSM only moves on enable ticks.
  always_comb begin
    state_nxt = state;
    if (enable) begin
      case (state)
        S_IDLE:  if (!rxd_s) state_nxt = S_START;
        S_START: if (tc_half) state_nxt = rxd_s ? S_IDLE : S_DATA;
        S_DATA: begin
          if (tc_full && (bit_cnt == 3'd7)) begin
`ifdef SPART_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
`ifdef SPART_RX_PARITY_EN
        S_PARITY: if (tc_full) state_nxt = S_STOP;
`endif
        S_STOP:  if (tc_full) state_nxt = rxd_s ? S_IDLE : S_BREAK;
        S_BREAK: if (rxd_s) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath strobes derived from the current state and tick count.
  always_comb begin
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
`ifdef SPART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    if (enable) begin
      case (state)
        S_START: begin
          bit_clr = 1'b1;
          if (tc_half) cnt_clr = 1'b1;
          else         cnt_inc = 1'b1;
        end
        S_DATA: begin
          if (tc_full) begin
            cnt_clr  = 1'b1;
            shift_en = 1'b1;
          end else begin
            cnt_inc  = 1'b1;
          end
        end
`ifdef SPART_RX_PARITY_EN
        S_PARITY: begin
          if (tc_full) begin
            cnt_clr = 1'b1;
            par_en  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tc_full) begin
            cnt_clr   = 1'b1;
            byte_done = 1'b1;
          end else begin
            cnt_inc   = 1'b1;
          end
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  // Tick counter, bit counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
`ifdef SPART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (cnt_clr)      tick_cnt <= '0;
      else if (cnt_inc) tick_cnt <= tick_cnt + 1'b1;
      if (bit_clr)       bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg <= {rxd_s, shreg[7:1]};
`ifdef SPART_RX_PARITY_EN
      if (par_en) par_bit <= rxd_s;
`endif
    end
  end

  // Bus-facing byte and flags; byte completion takes priority over rda_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= 8'h00;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else if (byte_done) begin
      rx_data     <= shreg;
      framing_err <= ~rxd_s;
      overrun_err <= rda;
      rda         <= 1'b1;
`ifdef SPART_RX_PARITY_EN
      parity_err  <= (^shreg) ^ par_bit;
`endif
    end else if (rda_clr) begin
      rda         <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule
